// File: rtl/lc3_mmio_device.sv
// LC-3 memory-mapped I/O device: keyboard (KBSR/KBDR) and display (DSR/DDR).
//
// Ports:
//   clk, rst            - clock and synchronous active-low reset
//   mmio_addr/wdata     - CPU address (MAR) and write data (MDR)
//   mmio_load/mmio_rd   - single-cycle store / load strobes
//   mmio_rdata          - combinational read data for mmio_addr
//   kb_valid/data/ready - keyboard byte source handshake (into a 4-deep FIFO)
//   disp_valid/data/ready - display byte sink handshake
//   IRQ/INTP/INTV       - level interrupt request, priority and vector
module lc3_mmio_device (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mmio_addr,
    input  logic [15:0] mmio_wdata,
    input  logic        mmio_load,
    input  logic        mmio_rd,
    output logic [15:0] mmio_rdata,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        IRQ,
    output logic [2:0]  INTP,
    output logic [7:0]  INTV
);

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    logic [7:0] fifo [4];
    logic [1:0] rd_ptr;
    logic [1:0] wr_ptr;
    logic [2:0] count;
    logic       kbie;
    logic       dsie;
    logic       dsr_rdy;
    logic [7:0] hold;

    logic sel_kbsr, sel_kbdr, sel_dsr, sel_ddr;
    logic kb_nonempty;
    logic push, pop;
    logic kbsr_wr, dsr_wr, ddr_wr;
    logic disp_xfer;
    logic kb_irq, ds_irq;

    assign sel_kbsr = (mmio_addr == KBSR_ADDR);
    assign sel_kbdr = (mmio_addr == KBDR_ADDR);
    assign sel_dsr  = (mmio_addr == DSR_ADDR);
    assign sel_ddr  = (mmio_addr == DDR_ADDR);

    assign kb_nonempty = (count != 3'd0);
    assign kb_ready    = (count != 3'd4);
    assign push        = kb_valid & kb_ready;
    assign pop         = mmio_rd & sel_kbdr & kb_nonempty;

    assign kbsr_wr   = mmio_load & sel_kbsr;
    assign dsr_wr    = mmio_load & sel_dsr;
    // A DDR store is dropped while a byte is still waiting for the display.
    assign ddr_wr    = mmio_load & sel_ddr & dsr_rdy;
    assign disp_xfer = disp_valid & disp_ready;

    assign disp_data = hold;

    assign kb_irq = kb_nonempty & kbie;
    assign ds_irq = dsr_rdy & dsie;
    assign IRQ    = kb_irq | ds_irq;
    assign INTP   = IRQ ? 3'd4 : 3'd0;
    assign INTV   = kb_irq ? 8'h80 : (ds_irq ? 8'h81 : 8'h00);

    always_comb begin
        mmio_rdata = 16'h0000;
        if (sel_kbsr) begin
            mmio_rdata = {kb_nonempty, kbie, 14'b0};
        end else if (sel_kbdr) begin
            mmio_rdata = kb_nonempty ? {8'h00, fifo[rd_ptr]} : 16'h0000;
        end else if (sel_dsr) begin
            mmio_rdata = {dsr_rdy, dsie, 14'b0};
        end else if (sel_ddr) begin
            mmio_rdata = {8'h00, hold};
        end
    end

    // FIFO storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= kb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr     <= 2'd0;
            wr_ptr     <= 2'd0;
            count      <= 3'd0;
            kbie       <= 1'b0;
            dsie       <= 1'b0;
            dsr_rdy    <= 1'b1;
            disp_valid <= 1'b0;
            hold       <= 8'h00;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase

            if (kbsr_wr) begin
                kbie <= mmio_wdata[14];
            end
            if (dsr_wr) begin
                dsie <= mmio_wdata[14];
            end

            // ddr_wr needs dsr_rdy, which is low whenever disp_valid is high,
            // so a store and a display transfer never coincide.
            if (ddr_wr) begin
                hold       <= mmio_wdata[7:0];
                dsr_rdy    <= 1'b0;
                disp_valid <= 1'b1;
            end else if (disp_xfer) begin
                dsr_rdy    <= 1'b1;
                disp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lc3_mmio_device.sv
module tb_lc3_mmio_device;

    logic        clk;
    logic        rst;
    logic [15:0] mmio_addr;
    logic [15:0] mmio_wdata;
    logic        mmio_load;
    logic        mmio_rd;
    logic [15:0] mmio_rdata;
    logic        kb_valid;
    logic [7:0]  kb_data;
    logic        kb_ready;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ready;
    logic        IRQ;
    logic [2:0]  INTP;
    logic [7:0]  INTV;

    lc3_mmio_device dut (
        .clk        (clk),
        .rst        (rst),
        .mmio_addr  (mmio_addr),
        .mmio_wdata (mmio_wdata),
        .mmio_load  (mmio_load),
        .mmio_rd    (mmio_rd),
        .mmio_rdata (mmio_rdata),
        .kb_valid   (kb_valid),
        .kb_data    (kb_data),
        .kb_ready   (kb_ready),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ready (disp_ready),
        .IRQ        (IRQ),
        .INTP       (INTP),
        .INTV       (INTV)
    );

    localparam int SEL_RDATA = 0, SEL_KBRDY = 1, SEL_DVALID = 2, SEL_DDATA = 3,
                   SEL_IRQ = 4, SEL_INTP = 5, SEL_INTV = 6;

    typedef struct {
        int          cyc;
        string       nm;
        int          sel;
        logic [15:0] v;
    } exp_t;

    exp_t       sq[$];
    logic [7:0] dq[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] observe(int sel);
        case (sel)
            SEL_RDATA:  return mmio_rdata;
            SEL_KBRDY:  return {15'b0, kb_ready};
            SEL_DVALID: return {15'b0, disp_valid};
            SEL_DDATA:  return {8'h00, disp_data};
            SEL_IRQ:    return {15'b0, IRQ};
            SEL_INTP:   return {13'b0, INTP};
            default:    return {8'h00, INTV};
        endcase
    endfunction

    // Monitor: checks expectations due this cycle and every display transfer.
    initial begin
        exp_t        e;
        logic [15:0] got;
        forever begin
            @(negedge clk);
            while (sq.size() > 0 && sq[0].cyc <= cyc) begin
                e = sq.pop_front();
                n_cmp++;
                if (e.cyc < cyc) begin
                    n_bad++;
                    $display("FAIL %s: not sampled in its cycle (due %0d, now %0d)", e.nm, e.cyc, cyc);
                end else begin
                    got = observe(e.sel);
                    if (got !== e.v) begin
                        n_bad++;
                        $display("FAIL %s: got %h, expected %h (cycle %0d)", e.nm, got, e.v, cyc);
                    end
                end
            end
            if (disp_valid === 1'b1 && disp_ready === 1'b1) begin
                n_cmp++;
                if (dq.size() == 0) begin
                    n_bad++;
                    $display("FAIL disp_xfer: unexpected byte %h", disp_data);
                end else begin
                    if (disp_data !== dq[0]) begin
                        n_bad++;
                        $display("FAIL disp_xfer: got %h, expected %h", disp_data, dq[0]);
                    end
                    void'(dq.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        mmio_load = 1'b0;
        mmio_rd   = 1'b0;
        kb_valid  = 1'b0;
    endtask

    task automatic expect_val(input string nm, input int sel, input logic [15:0] v);
        exp_t e;
        e.cyc = cyc;
        e.nm  = nm;
        e.sel = sel;
        e.v   = v;
        sq.push_back(e);
    endtask

    task automatic peek(input logic [15:0] a, input logic [15:0] v, input string nm);
        mmio_addr = a;
        expect_val(nm, SEL_RDATA, v);
        tick();
    endtask

    task automatic push_kb(input logic [7:0] d);
        kb_valid = 1'b1;
        kb_data  = d;
        tick();
    endtask

    task automatic pop_kb(input logic [15:0] v, input string nm);
        mmio_addr = 16'hFE02;
        mmio_rd   = 1'b1;
        expect_val(nm, SEL_RDATA, v);
        tick();
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        mmio_addr  = a;
        mmio_wdata = d;
        mmio_load  = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b0; mmio_addr = 16'h0000; mmio_wdata = 16'h0000;
        mmio_load = 1'b0; mmio_rd = 1'b0; kb_valid = 1'b0; kb_data = 8'h00;
        disp_ready = 1'b0;

        // Reset values
        tick(); tick();
        expect_val("rst_kb_ready", SEL_KBRDY, 16'h1);
        expect_val("rst_disp_valid", SEL_DVALID, 16'h0);
        expect_val("rst_disp_data", SEL_DDATA, 16'h0);
        expect_val("rst_irq", SEL_IRQ, 16'h0);
        expect_val("rst_intp", SEL_INTP, 16'h0);
        expect_val("rst_intv", SEL_INTV, 16'h0);
        peek(16'hFE04, 16'h8000, "rst_dsr");
        rst = 1'b1;
        tick();
        peek(16'h1234, 16'h0000, "unmapped_rd");

        // Single push and pop
        push_kb(8'h41);
        peek(16'hFE00, 16'h8000, "kbsr_one");
        peek(16'hFE02, 16'h0041, "kbdr_peek");
        pop_kb(16'h0041, "kbdr_pop");
        peek(16'hFE00, 16'h0000, "kbsr_empty");
        pop_kb(16'h0000, "pop_empty");

        // Fill to four, fifth byte refused
        for (int i = 1; i <= 4; i++) begin
            expect_val("kb_ready_space", SEL_KBRDY, 16'h1);
            push_kb(8'(i));
        end
        expect_val("kb_ready_full", SEL_KBRDY, 16'h0);
        push_kb(8'h05);
        for (int i = 1; i <= 4; i++) pop_kb(16'(i), "fifo_order");
        peek(16'hFE00, 16'h0000, "x05_dropped");

        // Push and pop on the same edge at count 2
        push_kb(8'hA1);
        push_kb(8'hA2);
        kb_valid = 1'b1; kb_data = 8'hA3;
        pop_kb(16'h00A1, "simul_pop");
        pop_kb(16'h00A2, "simul_next");
        pop_kb(16'h00A3, "simul_tail");
        peek(16'hFE00, 16'h0000, "simul_count");

        // Unmapped store must not touch registers
        wr(16'hFE08, 16'hFFFF);
        peek(16'hFE00, 16'h0000, "unmapped_wr");

        // Display with a stalled sink
        dq.push_back(8'h58);
        wr(16'hFE06, 16'h0058);
        expect_val("disp_valid_set", SEL_DVALID, 16'h1);
        expect_val("disp_data_58", SEL_DDATA, 16'h0058);
        peek(16'hFE04, 16'h0000, "dsr_busy");
        expect_val("ddr_before_2nd", SEL_RDATA, 16'h0058);
        wr(16'hFE06, 16'h0059);
        peek(16'hFE06, 16'h0058, "ddr_ignored");
        disp_ready = 1'b1;
        expect_val("disp_valid_hold", SEL_DVALID, 16'h1);
        tick();
        expect_val("disp_valid_clr", SEL_DVALID, 16'h0);
        peek(16'hFE04, 16'h8000, "dsr_ready");

        // Back-to-back stores right after each transfer edge
        dq.push_back(8'h5A);
        wr(16'hFE06, 16'h005A);
        tick();
        dq.push_back(8'h5B);
        wr(16'hFE06, 16'h005B);
        expect_val("disp_data_5b", SEL_DDATA, 16'h005B);
        tick();
        disp_ready = 1'b0;
        tick();

        // Interrupts
        wr(16'hFE00, 16'h4000);
        expect_val("irq_none", SEL_IRQ, 16'h0);
        tick();
        push_kb(8'h0D);
        expect_val("kb_irq", SEL_IRQ, 16'h1);
        expect_val("kb_intp", SEL_INTP, 16'h4);
        expect_val("kb_intv", SEL_INTV, 16'h0080);
        peek(16'hFE00, 16'hC000, "kbsr_ie");
        wr(16'hFE04, 16'h4000);
        expect_val("both_intv", SEL_INTV, 16'h0080);
        pop_kb(16'h000D, "irq_pop");
        expect_val("ds_irq", SEL_IRQ, 16'h1);
        expect_val("ds_intv", SEL_INTV, 16'h0081);
        tick();
        wr(16'hFE04, 16'h0000);

        // Reset mid-transfer
        push_kb(8'hB1); push_kb(8'hB2); push_kb(8'hB3);
        wr(16'hFE06, 16'h0077);
        expect_val("pre_rst_valid", SEL_DVALID, 16'h1);
        expect_val("pre_rst_irq", SEL_IRQ, 16'h1);
        rst = 1'b0;
        tick();
        expect_val("mid_rst_valid", SEL_DVALID, 16'h0);
        expect_val("mid_rst_irq", SEL_IRQ, 16'h0);
        expect_val("mid_rst_kb_ready", SEL_KBRDY, 16'h1);
        peek(16'hFE00, 16'h0000, "mid_rst_kbsr");
        rst = 1'b1;
        disp_ready = 1'b1;
        peek(16'hFE04, 16'h8000, "post_rst_dsr");
        peek(16'hFE02, 16'h0000, "post_rst_kbdr");
        tick(); tick();

        n_cmp++;
        if (sq.size() != 0 || dq.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: %0d checks and %0d display bytes outstanding, expected 0", sq.size(), dq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lc3_mmio_device.md
LC3_MMIO_DEVICE -- requirements
Module: lc3_mmio_device

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port mmio_addr, input, 16 bits: CPU address (MAR).
REQ-004 SHALL have port mmio_wdata, input, 16 bits: CPU write data (MDR).
REQ-005 SHALL have port mmio_load, input, 1 bit: the CPU write strobe, one cycle per store.
REQ-006 SHALL have port mmio_rd, input, 1 bit: the CPU read strobe, one cycle per load.
REQ-007 SHALL have port mmio_rdata, output, 16 bits: read data, combinational from mmio_addr.
REQ-008 SHALL have kb_valid (input, 1), kb_data (input, 8) and kb_ready (output, 1): the keyboard source handshake.
REQ-009 SHALL have disp_valid (output, 1), disp_data (output, 8) and disp_ready (input, 1): the display sink handshake.
REQ-010 SHALL have IRQ (output, 1), INTP (output, 3) and INTV (output, 8): the interrupt request to the datapath.

Function
REQ-011 SHALL decode four registers: KBSR x FE00, KBDR x FE02, DSR x FE04, DDR x FE06.
REQ-012 SHALL return x0000 on mmio_rdata for any other address.
REQ-013 SHALL have a 4-entry keyboard FIFO with 8-bit entries, a 2-bit read pointer, a 2-bit write pointer (both wrap 3->0) and a 3-bit count.
REQ-014 SHALL drive kb_ready = (count != 4).
REQ-015 SHALL push kb_data at the tail on a clock edge where kb_valid and kb_ready are both high.
REQ-016 SHALL return {1'b(count!=0), KBIE, 14'b0} on a KBSR read.
REQ-017 SHALL return {8'h00, head entry} on a KBDR read, or x0000 if the FIFO is empty.
REQ-018 SHALL pop the FIFO head on a clock edge with mmio_rd high, mmio_addr = x FE02 and count != 0; a pop while empty SHALL have no effect.
REQ-019 SHALL leave count unchanged when a push and a pop occur on the same edge; the head SHALL advance and the new byte SHALL enter at the tail.
REQ-020 SHALL, on a KBSR write, load only bit 14 (KBIE) from mmio_wdata; KBDR writes SHALL be ignored.
REQ-021 SHALL hold a display register dsr_rdy (reset 1) and an 8-bit holding register.
REQ-022 SHALL return {dsr_rdy, DSIE, 14'b0} on a DSR read.
REQ-023 SHALL return {8'h00, holding register} on a DDR read.
REQ-024 SHALL, on a DSR write, load only bit 14 (DSIE).
REQ-025 SHALL, on a DDR write with dsr_rdy = 1, latch mmio_wdata[7:0] into the holding register and set dsr_rdy = 0 and disp_valid = 1 on the same edge.
REQ-026 SHALL ignore a DDR write with dsr_rdy = 0, leaving the holding register unchanged.
REQ-027 SHALL hold disp_data equal to the holding register while disp_valid = 1.
REQ-028 SHALL, on a clock edge with disp_valid and disp_ready both high, clear disp_valid and set dsr_rdy.
REQ-029 SHALL allow a DDR write on the cycle right after the transfer edge.
REQ-030 SHALL drive IRQ high combinationally while kb_irq = (count != 0) & KBIE or ds_irq = dsr_rdy & DSIE is true; IRQ is level, not a pulse.
REQ-031 SHALL drive INTP = 3'd4 whenever IRQ = 1, and 3'd0 otherwise.
REQ-032 SHALL drive INTV = x80 when kb_irq, else x81 when ds_irq, else x00; the keyboard has priority.
REQ-033 SHALL let mmio_load and mmio_rd act only at x FE00, x FE02, x FE04 and x FE06; any other address SHALL cause no state change.

Reset
REQ-034 SHALL, on an edge with rst = 0, clear both FIFO pointers, count, KBIE, DSIE, disp_valid and the holding register, and set dsr_rdy = 1.
REQ-035 SHALL give these output values during reset: kb_ready = 1, disp_valid = 0, disp_data = x00, IRQ = 0, INTP = 0, INTV = 0.
REQ-036 SHALL, when reset is applied mid-transfer, drop any pending display byte and all FIFO contents without emitting them.

Verification
REQ-037 SHALL cover: push x41 -> KBSR reads x8000, KBDR reads x0041; then mmio_rd at x FE02 -> KBSR reads x0000.
REQ-038 SHALL cover: 5 pushes x01..x05 with no reads -> kb_ready = 0 after the 4th push; x05 never accepted; four pops return x0001..x0004.
REQ-039 SHALL cover: a push and a pop on the same edge with count = 2 -> count stays 2 and FIFO order is preserved.
REQ-040 SHALL cover: DDR write x0058 with disp_ready = 0 for 3 cycles -> disp_valid = 1, disp_data = x58, DSR = x0000; a second DDR write of x0059 is ignored; then disp_ready = 1 -> DSR = x8000 on the next cycle.
REQ-041 SHALL cover: KBSR write x4000, then push x0D -> IRQ = 1, INTP = 4, INTV = x80; with DSIE set as well -> INTV stays x80 until the FIFO empties, then becomes x81.
REQ-042 SHALL cover: reset asserted with 3 FIFO entries and disp_valid = 1 -> next cycle count = 0, disp_valid = 0, dsr_rdy = 1, IRQ = 0.
